// File: rtl/write_fsm.sv
// write_fsm: register-file write controller; captures a keypad decimal entry or an ALU result,
// waits for a non-zero destination register, then issues a single write strobe.
module write_fsm #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             nrst,
   input  logic             w_en,
   input  logic             key_valid,
   input  logic [3:0]       key_digit,
   input  logic             enter,
   input  logic [2:0]       reg_num,
   input  logic             result_ready,
   input  logic [WIDTH-1:0] alu_result,
   output logic [2:0]       reg_sel,
   output logic             wr_en,
   output logic [WIDTH-1:0] wr_data,
   output logic             busy,
   output logic             overflow,
   output logic             done
);
   typedef enum logic [2:0] {IDLE, ENTRY, DEST, WRITE, DONE} state_t;
   state_t           state_q, state_d;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic [2:0]       dest_q, dest_d;
   logic             ovf_q, ovf_d;
   logic [WIDTH+3:0] cand;
   assign cand = {4'b0, acc_q} * (WIDTH+4)'(10) + (WIDTH+4)'(key_digit);
   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      dest_d  = dest_q;
      ovf_d   = ovf_q;
      case (state_q)
         IDLE: begin
            if (result_ready) begin
               acc_d   = alu_result;
               state_d = DEST;
            end else if (w_en) begin
               acc_d   = '0;
               ovf_d   = 1'b0;
               state_d = ENTRY;
            end
         end
         ENTRY: begin
            // a digit arriving with enter is folded in before leaving
            if (key_valid && key_digit <= 4'd9) begin
               if (cand[WIDTH+3:WIDTH] == '0) acc_d = cand[WIDTH-1:0];
               else ovf_d = 1'b1;
            end
            if (enter) state_d = DEST;
         end
         DEST: begin
            if (reg_num != 3'd0) begin
               dest_d  = reg_num;
               state_d = WRITE;
            end
         end
         WRITE:   state_d = DONE;
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state_q <= IDLE;
         acc_q   <= '0;
         dest_q  <= '0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         dest_q  <= dest_d;
         ovf_q   <= ovf_d;
      end
   end
   assign wr_en    = state_q == WRITE;
   assign reg_sel  = wr_en ? dest_q : 3'd0;
   assign wr_data  = wr_en ? acc_q : '0;
   assign busy     = state_q != IDLE;
   assign done     = state_q == DONE;
   assign overflow = ovf_q;
endmodule

// File: tb/tb_write_fsm.sv
// tb_write_fsm: directed stimulus pushes expected writes into a queue; a monitor pops and
// compares on every write strobe and checks that done follows each write.
module tb_write_fsm;
   localparam int WIDTH = 8;
   logic             clk = 1'b0, nrst = 1'b0;
   logic             w_en = 1'b0, key_valid = 1'b0, enter = 1'b0, result_ready = 1'b0;
   logic [3:0]       key_digit = '0;
   logic [2:0]       reg_num = '0;
   logic [WIDTH-1:0] alu_result = '0;
   logic [2:0]       reg_sel;
   logic             wr_en, busy, overflow, done;
   logic [WIDTH-1:0] wr_data;
   logic [WIDTH+2:0] exp_q[$];
   logic             prev_wr = 1'b0;
   int               checks = 0, errors = 0;

   write_fsm #(.WIDTH(WIDTH)) dut (
      .clk(clk), .nrst(nrst), .w_en(w_en), .key_valid(key_valid), .key_digit(key_digit),
      .enter(enter), .reg_num(reg_num), .result_ready(result_ready), .alu_result(alu_result),
      .reg_sel(reg_sel), .wr_en(wr_en), .wr_data(wr_data), .busy(busy),
      .overflow(overflow), .done(done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (!nrst) prev_wr = 1'b0;
      else begin
         if (wr_en) begin
            if (exp_q.size() == 0) chk("unexpected_wr_en", 1, 0);
            else begin
               logic [WIDTH+2:0] e;
               e = exp_q.pop_front();
               chk("wr_reg_sel", reg_sel, e[WIDTH+2:WIDTH]);
               chk("wr_data", wr_data, e[WIDTH-1:0]);
            end
         end else begin
            chk("idle_reg_sel", reg_sel, 0);
            chk("idle_wr_data", wr_data, 0);
         end
         if (prev_wr || done) chk("done_after_write", done, prev_wr);
         prev_wr = wr_en;
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic key(input int d, input logic with_enter);
      key_valid = 1'b1;
      key_digit = 4'(d);
      enter     = with_enter;
      step();
      key_valid = 1'b0;
      key_digit = '0;
      enter     = 1'b0;
   endtask

   task automatic wait_idle(input string name);
      int n;
      n = 0;
      while (busy && n < 20) begin
         step();
         n++;
      end
      chk(name, busy, 0);
   endtask

   task automatic chk_zero(input string name);
      chk({name, "_wr_en"}, wr_en, 0);
      chk({name, "_busy"}, busy, 0);
      chk({name, "_done"}, done, 0);
      chk({name, "_overflow"}, overflow, 0);
      chk({name, "_reg_sel"}, reg_sel, 0);
      chk({name, "_wr_data"}, wr_data, 0);
   endtask

   task automatic dest(input int r);
      reg_num = 3'(r);
      step();
      reg_num = '0;
   endtask

   initial begin
      repeat (2) step();
      chk_zero("in_reset");
      nrst = 1'b1;
      @(negedge clk);
      chk_zero("after_release");
      step();
      // digit entry 1,2,7 -> reg 3
      exp_q.push_back({3'd3, 8'd127});
      w_en = 1'b1; step(); w_en = 1'b0;
      chk("entry_busy", busy, 1);
      key(1, 0); key(2, 0); key(7, 0);
      enter = 1'b1; step(); enter = 1'b0;
      dest(3);
      wait_idle("t1_idle");
      chk("t1_overflow", overflow, 0);
      // overflow: 2,5,6 -> 25 kept, flag set
      exp_q.push_back({3'd1, 8'd25});
      w_en = 1'b1; step(); w_en = 1'b0;
      key(2, 0); key(5, 0);
      chk("t2_no_ovf_yet", overflow, 0);
      key(6, 0);
      chk("t2_ovf_set", overflow, 1);
      enter = 1'b1; step(); enter = 1'b0;
      dest(1);
      wait_idle("t2_idle");
      chk("t2_ovf_sticky", overflow, 1);
      // ALU writeback with destination held at 0 for 3 cycles
      exp_q.push_back({3'd5, 8'h42});
      result_ready = 1'b1; alu_result = 8'h42; step(); result_ready = 1'b0; alu_result = '0;
      repeat (3) step();
      chk("t3_wait_busy", busy, 1);
      chk("t3_ovf_kept", overflow, 1);
      dest(5);
      wait_idle("t3_idle");
      // simultaneous start: writeback wins, keys ignored
      exp_q.push_back({3'd2, 8'h11});
      w_en = 1'b1; result_ready = 1'b1; alu_result = 8'h11; step();
      w_en = 1'b0; result_ready = 1'b0; alu_result = '0;
      key(5, 1);
      dest(2);
      wait_idle("t4_idle");
      chk("t4_ovf_kept", overflow, 1);
      // edge keys: 12 ignored, 9 with enter applied
      exp_q.push_back({3'd7, 8'd9});
      w_en = 1'b1; step(); w_en = 1'b0;
      chk("t5_ovf_cleared", overflow, 0);
      key(12, 0);
      key(9, 1);
      dest(7);
      wait_idle("t5_idle");
      chk("t5_overflow", overflow, 0);
      // reset mid-entry aborts without a write
      w_en = 1'b1; step(); w_en = 1'b0;
      key(4, 0); key(4, 0);
      nrst = 1'b0;
      #1;
      chk_zero("async_reset");
      step();
      nrst = 1'b1;
      repeat (3) step();
      chk("t6_idle_after_reset", busy, 0);
      exp_q.push_back({3'd4, 8'd3});
      w_en = 1'b1; step(); w_en = 1'b0;
      key(3, 0);
      enter = 1'b1; step(); enter = 1'b0;
      dest(4);
      wait_idle("t6_idle");
      repeat (3) step();
      chk("pending_writes", exp_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #20000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1);
   end
endmodule

// File: doc/write_fsm.md
Name: write_fsm

Overview:
- Write-side controller for the calculator register file; it is the counterpart of the operand-read sequencer.
- Accepts either a decimal value typed on the keypad or an ALU result flagged ready.
- Waits for a non-zero destination register number, then issues exactly one register-file write strobe with the value.
- Sits between keypad decode / ALU and the register file write port.

Parameters:
- WIDTH, 8, data width of accumulator, ALU result and write data.

Ports:
- clk  input  1  system clock, rising edge.
- nrst  input  1  asynchronous active-low reset.
- w_en  input  1  start manual keypad entry (sampled in IDLE only).
- key_valid  input  1  one-cycle strobe: key_digit holds a new key.
- key_digit  input  4  BCD digit; values 10-15 are ignored.
- enter  input  1  ends digit entry.
- reg_num  input  3  destination register number; 0 means none selected.
- result_ready  input  1  ALU result is available on alu_result.
- alu_result  input  WIDTH  ALU result value.
- reg_sel  output  3  register-file write address.
- wr_en  output  1  register-file write strobe, one cycle.
- wr_data  output  WIDTH  register-file write data.
- busy  output  1  high in any state other than IDLE.
- overflow  output  1  sticky flag: a digit was rejected for exceeding the range.
- done  output  1  one-cycle pulse after the write.

Behaviour:
- Reset (asynchronous, nrst low): state=IDLE, acc=0, dest=0, overflow=0. All outputs are 0 while nrst is low and on the first cycle after release.
- Reset asserted mid-operation aborts the operation. No write is issued.
- States: IDLE, ENTRY, DEST, WRITE, DONE.
- IDLE:
  - result_ready=1: acc<=alu_result, go to DEST.
  - else w_en=1: acc<=0, overflow<=0, go to ENTRY.
  - result_ready has priority when both inputs are high in the same cycle. w_en is then ignored.
- ENTRY:
  - key_valid=1 with key_digit<=9: candidate = acc*10 + key_digit, computed at WIDTH+4 bits.
  - If candidate <= 2^WIDTH-1: acc<=candidate.
  - Otherwise acc is unchanged and overflow<=1.
  - key_digit>9 is ignored with no flag.
  - enter=1: go to DEST. If key_valid is high in the same cycle, the digit is applied first.
  - result_ready is ignored in ENTRY.
- DEST:
  - Hold while reg_num==0.
  - reg_num!=0: dest<=reg_num, go to WRITE.
- WRITE (one cycle): wr_en=1, reg_sel=dest, wr_data=acc. Always go to DONE.
- DONE (one cycle): done=1, then go to IDLE.
- Outside WRITE: wr_en=0, reg_sel=0, wr_data=0.
- busy=1 in ENTRY, DEST, WRITE and DONE.
- overflow holds its value until the next w_en accepted in IDLE or until reset.
- Latency: write strobe on the cycle after the non-zero reg_num is sampled in DEST. done follows one cycle later.
- Minimum IDLE-to-IDLE for the writeback path: 4 cycles (IDLE, DEST, WRITE, DONE).
- Empty entry (enter with no digits) writes 0.

Test Plan:
- WIDTH=8. Digit entry: w_en, digits 1,2,7, enter, reg_num=3 -> wr_en high exactly 1 cycle with reg_sel=3 and wr_data=127 (0x7F). done pulses the next cycle. busy drops with IDLE. overflow=0.
- Overflow: w_en, digits 2,5,6, enter, reg_num=1 -> overflow=1 after the '6'. Write carries wr_data=25. overflow stays 1 until the next w_en, then clears.
- ALU writeback: result_ready=1 with alu_result=0x42 in IDLE, reg_num=0 for 3 cycles, then 5 -> no wr_en while reg_num=0. Then wr_en with reg_sel=5 and wr_data=0x42.
- Simultaneous start: w_en=1 and result_ready=1 with alu_result=0x11 in the same IDLE cycle, then reg_num=2 -> writeback path taken. Writes 0x11 to reg 2. Keys pressed meanwhile have no effect.
- Edge keys: w_en, key_digit=12 (ignored), digit 9 with enter in the same cycle, reg_num=7 -> writes 9 to reg 7. overflow=0.
- Reset mid-op: w_en, digits 4,4, nrst low for 1 cycle during ENTRY -> outputs are 0 immediately and no wr_en follows. A new entry of 3, enter, reg_num=4 writes 3 (acc was cleared).
